// File: rtl/cla_nibble_serial_adder.sv
// cla_nibble_serial_adder
//   WIDTH-bit adder built around a single 4-bit carry-look-ahead slice.
//   An operand pair is accepted over a valid/ready handshake. The pair is
//   added one nibble per clock, LSB nibble first. The result (sum + carry-out)
//   is presented over a second valid/ready handshake.
//   Optional feature: define CLA_SERIAL_OVF_EN to add the out_ovf port
//   (two's-complement overflow, registered with the result).

// Pure combinational 4-bit carry-look-ahead slice with full sum-of-products
// carries; c2 is exported only when the overflow output needs it.
module cla_nibble_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
`ifdef CLA_SERIAL_OVF_EN
    output logic       c2_out,
`endif
    output logic       c3
);
    logic [3:0] g;
    logic [3:0] p;
    logic       c0;
    logic       c1;
    logic       c2;

    assign g = a & b;
    assign p = a ^ b;

    assign c0 = g[0]
              | (p[0] & cin);
    assign c1 = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
    assign c2 = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
    assign c3 = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c2, c1, c0, cin};

`ifdef CLA_SERIAL_OVF_EN
    assign c2_out = c2;
`endif
endmodule

module cla_nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
`ifdef CLA_SERIAL_OVF_EN
    output logic             out_ovf,
`endif
    output logic             busy
);
    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NIB - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    // Reject widths that cannot be split into whole nibbles.
    generate
        if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
            $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  result;
    logic [WIDTH-1:0]  result_next;
    logic              carry;
    logic [IDXW-1:0]   idx;
    logic              last_step;

    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [3:0]        slice_s;
    logic              slice_c3;
`ifdef CLA_SERIAL_OVF_EN
    logic              slice_c2;
`endif

    // Handshake and status outputs are pure decodes of the registered state.
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign last_step = (idx == IDX_LAST);

    // Nibble idx of each captured operand feeds the shared slice.
    assign nib_a = op_a[{idx, 2'b00} +: 4];
    assign nib_b = op_b[{idx, 2'b00} +: 4];

    cla_nibble_slice u_slice (
        .a      (nib_a),
        .b      (nib_b),
        .cin    (carry),
        .s      (slice_s),
`ifdef CLA_SERIAL_OVF_EN
        .c2_out (slice_c2),
`endif
        .c3     (slice_c3)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE, step NIB times in RUN, wait in DONE.
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Result with the current slice sum merged into nibble idx.
    always_comb begin
        result_next = result;
        result_next[{idx, 2'b00} +: 4] = slice_s;
    end

    // Datapath: capture operands on accept, one nibble per RUN cycle, and
    // load the output registers on the final nibble so they only change
    // when entering DONE.
    // NOTE: these few datapath flops are all reset, so a reset mid-addition
    // leaves no stale operand, carry or partial result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
            out_ovf  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= in_a;
                        op_b  <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    result <= result_next;
                    carry  <= slice_c3;
                    if (last_step) begin
                        idx      <= '0;
                        out_sum  <= result_next;
                        out_cout <= slice_c3;
`ifdef CLA_SERIAL_OVF_EN
                        out_ovf  <= slice_c2 ^ slice_c3;
`endif
                    end else begin
                        idx <= idx + IDX_ONE;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
